// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_ctrl_pkg;

    // Controller states; StTrap is only reachable when ILLEGAL_TRAP_EN is defined.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StTrap     = 4'd11
    } state_t;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    // Immediate format select for the sign-extension unit
    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Result bus select
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResReadData  = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // Coarse ALU operation requested by the FSM
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU control encodings
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    // Immediate format depends on opcode alone; unlisted opcodes default to I-type.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OpStore: imm = ImmS;
            OpBeq:   imm = ImmB;
            OpJal:   imm = ImmJ;
            default: imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU decoder: coarse ALU op plus funct fields -> ALUControl.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Decode funct fields; funct7b5 only selects sub for register-register ops (op[5]=1).
    always_comb begin
        alu_control = AluAdd;
        case (alu_op)
            AluOpAdd: alu_control = AluAdd;
            AluOpSub: alu_control = AluSub;
            AluOpFunct: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alu_control = AluSlt;
                    3'b110:  alu_control = AluOr;
                    3'b111:  alu_control = AluAnd;
                    default: alu_control = AluAdd;
                endcase
            end
            default: alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Optional feature: define ILLEGAL_TRAP_EN to trap on unknown opcodes (adds illegal_instr output).
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               AdrSrc,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               PCWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
`ifdef ILLEGAL_TRAP_EN
    output logic               illegal_instr,
`endif
    output logic [STATE_W-1:0] state_o
);

    state_t     state_q, state_d;
    logic       req_raw, irw_raw, memw_raw, regw_raw, pc_update, branch;
    logic [1:0] alu_op;
    logic       illegal_raw;

    // State register; reset aborts any in-flight instruction and returns to fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; enables gated by mem_ready/Zero where required.
    always_comb begin
        state_d     = state_q;
        req_raw     = 1'b0;
        AdrSrc      = 1'b0;
        irw_raw     = 1'b0;
        memw_raw    = 1'b0;
        regw_raw    = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        ResultSrc   = ResAluOut;
        ALUSrcA     = SrcAPc;
        ALUSrcB     = SrcBRs2;
        alu_op      = AluOpAdd;
        illegal_raw = 1'b0;
        unique case (state_q)
            StFetch: begin
                req_raw   = 1'b1;
                ALUSrcA   = SrcAPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                irw_raw   = mem_ready;
                pc_update = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Compute the branch target early; used by beq.
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
`ifdef ILLEGAL_TRAP_EN
                    default:         state_d = StTrap;
`else
                    default:         state_d = StFetch;
`endif
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                req_raw = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResReadData;
                regw_raw  = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                req_raw  = 1'b1;
                AdrSrc   = 1'b1;
                memw_raw = mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StExecuteR: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBRs2;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                regw_raw  = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBRs2;
                alu_op    = AluOpSub;
                ResultSrc = ResAluOut;
                branch    = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                // ALU forms the link value OldPC+4 while PC loads the target from ALUOut.
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBFour;
                alu_op    = AluOpAdd;
                ResultSrc = ResAluOut;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
`ifdef ILLEGAL_TRAP_EN
            StTrap: begin
                illegal_raw = 1'b1;
                state_d     = StTrap;
            end
`endif
            default: state_d = StFetch;
        endcase
    end

    // Write enables and request are held low for the whole time reset is asserted.
    assign mem_req  = rst_n & req_raw;
    assign IRWrite  = rst_n & irw_raw;
    assign MemWrite = rst_n & memw_raw;
    assign RegWrite = rst_n & regw_raw;
    assign PCWrite  = rst_n & (pc_update | (branch & Zero));

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_raw;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_raw;
`endif

    assign ImmSrc  = imm_src_of(op);
    assign state_o = STATE_W'(state_q);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: table-driven per-instruction cycle model
// compared every cycle, plus directed literal checks.
module tb_multicycle_control_fsm;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0010011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, AdrSrc, IRWrite, MemWrite, RegWrite, PCWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCWrite    (PCWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .state_o    (state_o)
    );

    // Special codes in the row table: -1 don't care, RDY = mem_ready, ZR = Zero, FN = funct ALU.
    localparam int DC = -1;
    localparam int RDY = 100;
    localparam int ZR = 101;
    localparam int FN = 102;

    typedef struct {
        state_t st;
        int mreq, adr, irw, memw, regw, pcw, res, srca, srcb, aluc;
        bit waits;
        bit sticky;
    } row_t;

    row_t rows[12];
    int   seq[7][6];
    int   seq_len[7];
    int   imm_exp[7];
    int   m_pos = 0;

    function automatic int classify(input logic [6:0] o);
        case (o)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            default:    return 6;
        endcase
    endfunction

    function automatic int alu_ref(input logic op5, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (op5 && f7) ? 1 : 0;
            3'd2:    return 5;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_field(input string name, input logic [31:0] act, input int code);
        int e;
        if (code == DC) return;
        if (code == RDY) e = int'(mem_ready);
        else if (code == ZR) e = int'(Zero);
        else if (code == FN) e = alu_ref(op[5], funct3, funct7b5);
        else e = code;
        check(name, act, e);
    endtask

    // Model position within the current instruction's cycle sequence.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0;
        end else begin
            int c, r;
            c = classify(op);
            r = seq[c][m_pos];
            if (!(rows[r].sticky || (rows[r].waits && !mem_ready)))
                m_pos <= (m_pos + 1 == seq_len[c]) ? 0 : m_pos + 1;
        end
    end

    // Pulse counters, sampled mid-cycle.
    int n_memw = 0, n_regw = 0, n_pcw = 0;
    always @(negedge clk) begin
        if (MemWrite) n_memw <= n_memw + 1;
        if (RegWrite) n_regw <= n_regw + 1;
        if (PCWrite)  n_pcw  <= n_pcw + 1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_enables", {27'd0, MemWrite, RegWrite, PCWrite, IRWrite, mem_req}, 0);
            check("rst_state", state_o, StFetch);
        end else begin
            int c, r;
            c = classify(op);
            r = seq[c][m_pos];
            check("state", state_o, rows[r].st);
            chk_field("mem_req", mem_req, rows[r].mreq);
            chk_field("AdrSrc", AdrSrc, rows[r].adr);
            chk_field("IRWrite", IRWrite, rows[r].irw);
            chk_field("MemWrite", MemWrite, rows[r].memw);
            chk_field("RegWrite", RegWrite, rows[r].regw);
            chk_field("PCWrite", PCWrite, rows[r].pcw);
            chk_field("ResultSrc", ResultSrc, rows[r].res);
            chk_field("ALUSrcA", ALUSrcA, rows[r].srca);
            chk_field("ALUSrcB", ALUSrcB, rows[r].srcb);
            chk_field("ALUControl", ALUControl, rows[r].aluc);
            if (m_pos > 0) chk_field("ImmSrc", ImmSrc, imm_exp[c]);
`ifdef ILLEGAL_TRAP_EN
            check("illegal_instr", illegal_instr, (rows[r].st == StTrap) ? 1 : 0);
`endif
        end
    end

    logic [2:0] third_aluc;
    logic [1:0] third_imm;

    // Runs one instruction from FETCH back to FETCH; optional mem_ready stall at one position.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int stall_pos, input int stalls,
                             output int cycles, output int memw, output int regw,
                             output int pcw);
        int left, b_memw, b_regw, b_pcw;
        bit done;
        left = stalls;
        done = 0;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        b_memw = n_memw; b_regw = n_regw; b_pcw = n_pcw;
        cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (m_pos == stall_pos && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end else begin
                mem_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (m_pos == 2) begin
                third_aluc = ALUControl;
                third_imm  = ImmSrc;
            end
            if (m_pos == 0) done = 1;
        end
        check("instr_done_in_budget", done, 1);
        memw = n_memw - b_memw;
        regw = n_regw - b_regw;
        pcw  = n_pcw - b_pcw;
    endtask

    initial begin
        int cyc, mw, rw, pw;
        //           st          mreq adr irw  memw regw pcw  res srca srcb aluc waits sticky
        rows[0]  = '{StFetch,    1,   0,  RDY, 0,   0,   RDY, 2,  0,   2,   0,   1'b1, 1'b0};
        rows[1]  = '{StDecode,   0,   DC, 0,   0,   0,   0,   DC, 1,   1,   0,   1'b0, 1'b0};
        rows[2]  = '{StMemAdr,   0,   DC, 0,   0,   0,   0,   DC, 2,   1,   0,   1'b0, 1'b0};
        rows[3]  = '{StMemRead,  1,   1,  0,   0,   0,   0,   DC, DC,  DC,  DC,  1'b1, 1'b0};
        rows[4]  = '{StMemWb,    0,   DC, 0,   0,   1,   0,   1,  DC,  DC,  DC,  1'b0, 1'b0};
        rows[5]  = '{StMemWrite, 1,   1,  0,   RDY, 0,   0,   DC, DC,  DC,  DC,  1'b1, 1'b0};
        rows[6]  = '{StExecuteR, 0,   DC, 0,   0,   0,   0,   DC, 2,   0,   FN,  1'b0, 1'b0};
        rows[7]  = '{StExecuteI, 0,   DC, 0,   0,   0,   0,   DC, DC,  1,   FN,  1'b0, 1'b0};
        rows[8]  = '{StAluWb,    0,   DC, 0,   0,   1,   0,   0,  DC,  DC,  DC,  1'b0, 1'b0};
        rows[9]  = '{StBeq,      0,   DC, 0,   0,   0,   ZR,  0,  2,   0,   1,   1'b0, 1'b0};
        rows[10] = '{StJal,      0,   DC, 0,   0,   0,   1,   0,  1,   2,   0,   1'b0, 1'b0};
        rows[11] = '{StTrap,     0,   DC, 0,   0,   0,   0,   DC, DC,  DC,  DC,  1'b0, 1'b1};
        seq[0] = '{0, 1, 2, 3, 4, 0};  seq_len[0] = 5;  imm_exp[0] = 0;
        seq[1] = '{0, 1, 2, 5, 0, 0};  seq_len[1] = 4;  imm_exp[1] = 1;
        seq[2] = '{0, 1, 6, 8, 0, 0};  seq_len[2] = 4;  imm_exp[2] = DC;
        seq[3] = '{0, 1, 7, 8, 0, 0};  seq_len[3] = 4;  imm_exp[3] = 0;
        seq[4] = '{0, 1, 9, 0, 0, 0};  seq_len[4] = 3;  imm_exp[4] = 2;
        seq[5] = '{0, 1, 10, 8, 0, 0}; seq_len[5] = 4;  imm_exp[5] = 3;
`ifdef ILLEGAL_TRAP_EN
        seq[6] = '{0, 1, 11, 0, 0, 0}; seq_len[6] = 3;  imm_exp[6] = DC;
`else
        seq[6] = '{0, 1, 0, 0, 0, 0};  seq_len[6] = 2;  imm_exp[6] = DC;
`endif

        // Reset and release
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_state_fetch", state_o, StFetch);
        check("reset_mem_req", mem_req, 1);
        #1;  // back to posedge+3 in FETCH; run_instr waits for the edge itself

        // lw x5,8(x1)
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("lw_cycles", cyc, 5);
        check("lw_regwrite_pulses", rw, 1);
        check("lw_immsrc", third_imm, 2'b00);
        // sw with three wait cycles in MEMWRITE
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3, 3, cyc, mw, rw, pw);
        check("sw_stall_cycles", cyc, 7);
        check("sw_memwrite_pulses", mw, 1);
        check("sw_regwrite_pulses", rw, 0);
        // beq taken / not taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, -1, 0, cyc, mw, rw, pw);
        check("beq_taken_cycles", cyc, 3);
        check("beq_taken_pcwrite", pw, 2);
        check("beq_aluc", third_aluc, 3'b001);
        check("beq_immsrc", third_imm, 2'b10);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("beq_not_taken_cycles", cyc, 3);
        check("beq_not_taken_pcwrite", pw, 1);
        // ALU decode cases
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("sub_aluc", third_aluc, 3'b001);
        check("r_cycles", cyc, 4);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("add_aluc", third_aluc, 3'b000);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("addi_f7b5_aluc", third_aluc, 3'b000);
        check("addi_regwrite_pulses", rw, 1);
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("or_aluc", third_aluc, 3'b011);
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("slt_aluc", third_aluc, 3'b101);
        run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("andi_aluc", third_aluc, 3'b010);
        // jal
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("jal_cycles", cyc, 4);
        check("jal_pcwrite_pulses", pw, 2);
        check("jal_immsrc", ImmSrc, 2'b11);

        // Reset in the middle of a store strobe
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 10 && m_pos != 3; i++) begin
            if (m_pos == 3) break;
            mem_ready = (m_pos == 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        check("reach_memwrite", state_o, StMemWrite);
        mem_ready = 1'b1;
        #1;
        check("memwrite_before_reset", MemWrite, 1);
        #1 rst_n = 1'b0;
        #1;
        check("memwrite_drops_in_reset", MemWrite, 0);
        check("state_fetch_in_reset", state_o, StFetch);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_reset_state", state_o, StFetch);
        check("post_reset_mem_req", mem_req, 1);
        #1;

        // Unknown opcode
`ifdef ILLEGAL_TRAP_EN
        op = 7'b1111111;
        mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("trap_state", state_o, StTrap);
        check("trap_illegal", illegal_instr, 1);
        check("trap_no_pcwrite", PCWrite, 0);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
`else
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, -1, 0, cyc, mw, rw, pw);
        check("illegal_nop_cycles", cyc, 2);
        check("illegal_no_regwrite", rw, 0);
        check("illegal_no_memwrite", mw, 0);
        check("illegal_pcwrite_fetch_only", pw, 1);
`endif
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
